// File: rtl/window_binconv.sv
// -----------------------------------------------------------------------------
// window_binconv
//
// Binary convolution back-end that sits behind the binary sliding-window
// stage. It takes one KERNEL_SIZE x KERNEL_SIZE binary window per handshake
// and XNORs it with a stored binary kernel. The matching bits are counted, and
// the count is compared against a stored threshold. The result is one
// output-feature-map bit per window, written to an external RAM write port.
// The block also requests each next window from the window stage. It counts
// windows until the whole OUT_ROW_LEN x OUT_COL_LEN map has been written.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-low reset
//   w_load     load w_in / thresh_in into the kernel registers (IDLE/DONE only)
//   w_in       binary kernel, bit i pairs with win_in[i]
//   thresh_in  activation threshold
//   start      begin processing one output map (accepted in IDLE only)
//   win_in     current window bits
//   win_valid  window on win_in is valid, sampled at posedge
//   slide      one-cycle request for the next window
//   out_wen    output RAM write enable
//   out_addr   output RAM address (row-major window index)
//   out_data   output bit: popcount >= threshold
//   pop_out    popcount of the window being written
//   busy       high from accepted start until DONE is entered
//   done       one-cycle pulse in the cycle following the final write edge
//   overrun    sticky: win_valid seen while not waiting for a window
// -----------------------------------------------------------------------------
module window_binconv #(
    parameter int KERNEL_SIZE    = 3,
    parameter int OUT_ROW_LEN    = 30,
    parameter int OUT_COL_LEN    = 30,
    parameter int OUT_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   w_load,
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]     w_in,
    input  logic [CNT_WIDTH-1:0]                   thresh_in,
    input  logic                                   start,
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]     win_in,
    input  logic                                   win_valid,
    output logic                                   slide,
    output logic                                   out_wen,
    output logic [OUT_ADDR_WIDTH-1:0]              out_addr,
    output logic                                   out_data,
    output logic [CNT_WIDTH-1:0]                   pop_out,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overrun
);

    localparam int N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int TOTAL = OUT_ROW_LEN * OUT_COL_LEN;
    localparam logic [OUT_ADDR_WIDTH-1:0] LAST_ADDR = OUT_ADDR_WIDTH'(TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WIN  = 3'd1,
        S_REQ_SLIDE = 3'd2,
        S_DRAIN     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Kernel and threshold
    logic [N-1:0]              w_reg;
    logic [CNT_WIDTH-1:0]      thresh_reg;

    // Control counters
    logic [OUT_ADDR_WIDTH-1:0] win_cnt_reg;
    logic                      drain_cnt_reg;

    // Stage 1: XNOR of window and kernel, tagged with its output address
    logic                      s1_valid_reg;
    logic [N-1:0]              s1_xnor_reg;
    logic [OUT_ADDR_WIDTH-1:0] s1_addr_reg;

    // Stage 2: popcount
    logic                      s2_valid_reg;
    logic [CNT_WIDTH-1:0]      s2_pop_reg;
    logic [OUT_ADDR_WIDTH-1:0] s2_addr_reg;

    // Output write port
    logic                      out_wen_reg;
    logic [OUT_ADDR_WIDTH-1:0] out_addr_reg;
    logic                      out_data_reg;
    logic [CNT_WIDTH-1:0]      pop_out_reg;
    logic                      overrun_reg;

    // Decoded handshake events
    logic                      start_ok;
    logic                      accept;
    logic                      last_win;
    logic                      kernel_wr;
    logic                      stray_valid;
    logic [N-1:0]              xnor_bits;

    assign start_ok    = (state_reg == S_IDLE) && start;
    assign accept      = (state_reg == S_WAIT_WIN) && win_valid;
    assign last_win    = (win_cnt_reg == LAST_ADDR);
    assign kernel_wr   = w_load && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign stray_valid = win_valid && (state_reg != S_WAIT_WIN);

    // A weight bit and a window bit "agree" when they are equal.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_xnor
            assign xnor_bits[gi] = ~(win_in[gi] ^ w_reg[gi]);
        end
    endgenerate

    // Zero-extended sum of the agreement bits. CNT_WIDTH holds N, so the
    // sum cannot overflow.
    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [N-1:0] v);
        logic [CNT_WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + CNT_WIDTH'(v[i]);
        end
        return s;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                // The first window is already on its way; no slide needed.
                if (start) begin
                    state_next = S_WAIT_WIN;
                end
            end
            S_WAIT_WIN: begin
                if (win_valid) begin
                    state_next = last_win ? S_DRAIN : S_REQ_SLIDE;
                end
            end
            S_REQ_SLIDE: begin
                state_next = S_WAIT_WIN;
            end
            S_DRAIN: begin
                // Two cycles let the final window reach the write port.
                if (drain_cnt_reg) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        slide = 1'b0;
        done  = 1'b0;
        busy  = 1'b0;
        case (state_reg)
            S_WAIT_WIN:  busy  = 1'b1;
            S_REQ_SLIDE: begin
                busy  = 1'b1;
                slide = 1'b1;
            end
            S_DRAIN:     busy  = 1'b1;
            S_DONE:      done  = 1'b1;
            default:     ;
        endcase
    end

    // ------------------------------------------------------------------
    // Kernel registers, counters and sticky overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_reg         <= '0;
            thresh_reg    <= '0;
            win_cnt_reg   <= '0;
            drain_cnt_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (kernel_wr) begin
                w_reg      <= w_in;
                thresh_reg <= thresh_in;
            end

            if (start_ok) begin
                win_cnt_reg <= '0;
            end else if (accept && !last_win) begin
                // The counter parks on the final index instead of wrapping.
                win_cnt_reg <= win_cnt_reg + 1'b1;
            end

            if (state_reg == S_DRAIN) begin
                drain_cnt_reg <= ~drain_cnt_reg;
            end else begin
                drain_cnt_reg <= 1'b0;
            end

            // An accepted start takes priority over a stray win_valid.
            if (start_ok) begin
                overrun_reg <= 1'b0;
            end else if (stray_valid) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath pipeline: XNOR -> popcount -> threshold/write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_xnor_reg  <= '0;
            s1_addr_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_pop_reg   <= '0;
            s2_addr_reg  <= '0;
            out_wen_reg  <= 1'b0;
            out_addr_reg <= '0;
            out_data_reg <= 1'b0;
            pop_out_reg  <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_xnor_reg <= xnor_bits;
                s1_addr_reg <= win_cnt_reg;
            end

            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_pop_reg  <= popcount(s1_xnor_reg);
                s2_addr_reg <= s1_addr_reg;
            end

            // Address, data and popcount hold their last written values
            // while no write is in progress.
            out_wen_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_addr_reg <= s2_addr_reg;
                out_data_reg <= (s2_pop_reg >= thresh_reg);
                pop_out_reg  <= s2_pop_reg;
            end
        end
    end

    assign out_wen  = out_wen_reg;
    assign out_addr = out_addr_reg;
    assign out_data = out_data_reg;
    assign pop_out  = pop_out_reg;
    assign overrun  = overrun_reg;

endmodule
